// File: rtl/sig_mon_pkg.sv
// sig_mon_pkg: shared definitions for the commit signature monitor.
//   sig_state_e  - run state (ST_RUN after reset; ST_PASS/ST_FAIL/ST_TIMEOUT absorbing)
//   DEFAULT_TAPS - default feedback mask (bits 31,30,29,9)
//   sig_step     - one signature step: t = sig ^ mix, next = {t[w-2:0], ^(t & taps)}
package sig_mon_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } sig_state_e;

   localparam logic [31:0] DEFAULT_TAPS = 32'hE000_0200;

   // sig_step works on a wide container so one function serves every XLEN up to
   // SIG_MAX_W; the width argument masks off the unused upper bits.
   localparam int unsigned SIG_MAX_W = 128;
   typedef logic [SIG_MAX_W-1:0] sig_word_t;

   function automatic sig_word_t sig_step(input sig_word_t   sig,
                                          input sig_word_t   mix,
                                          input sig_word_t   taps,
                                          input int unsigned width = 32);
      sig_word_t mask;
      sig_word_t t;
      logic      fb;
      mask = (width >= SIG_MAX_W) ? '1 : ((sig_word_t'(1) << width) - sig_word_t'(1));
      t    = (sig ^ mix) & mask;
      fb   = ^(t & taps & mask);
      return ((t << 1) | sig_word_t'(fb)) & mask;
   endfunction

endpackage

// File: rtl/sig_lfsr_reg.sv
// sig_lfsr_reg: XLEN-bit rolling signature register.
//   clk, reset (sync, active-low) - clocking; reset clears the signature to 0
//   step   - fold mix into the signature on this edge
//   freeze - hold the signature regardless of step (run has ended)
//   mix    - value XOR-ed into the signature before the shift
//   sig    - current signature
module sig_lfsr_reg
   import sig_mon_pkg::*;
#(
   parameter int              XLEN = 32,
   parameter logic [XLEN-1:0] TAPS = XLEN'(DEFAULT_TAPS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            step,
   input  logic            freeze,
   input  logic [XLEN-1:0] mix,
   output logic [XLEN-1:0] sig
);

   logic [XLEN-1:0] next_sig;

   assign next_sig = XLEN'(sig_step(sig_word_t'(sig), sig_word_t'(mix),
                                    sig_word_t'(TAPS), XLEN));

   always_ff @(posedge clk) begin
      if (!reset) begin
         sig <= '0;
      end else if (step && !freeze) begin
         sig <= next_sig;
      end
   end

endmodule

// File: rtl/commit_sig_monitor.sv
// commit_sig_monitor: run monitor for a RISC-V core's commit/store stream.
// Folds sampled instr^pc and store data into a rolling signature and decides
// pass / fail / timeout from store traffic.
//   clk, reset (sync, active-low)
//   sample_en, instr, pc              - instruction boundary sample
//   mem_write, data_adr, write_data   - store strobe, address, data
//   signature                         - current or frozen signature
//   done, pass, fail, timeout         - sticky status (one-hot once done)
//   cycle_count                       - clocks spent in RUN
//   store_count                       - stores seen in RUN, saturating
//   state                             - FSM state, for debug/checkers
module commit_sig_monitor
   import sig_mon_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter logic [XLEN-1:0] TAPS           = XLEN'(DEFAULT_TAPS),
   parameter logic [XLEN-1:0] PASS_ADR       = XLEN'(100),
   parameter logic [XLEN-1:0] PASS_DATA      = XLEN'(25),
   parameter logic [XLEN-1:0] SCRATCH_ADR    = XLEN'(96),
   parameter int              TIMEOUT_CYCLES = 10000,
   localparam int             CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            sample_en,
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   input  logic            mem_write,
   input  logic [XLEN-1:0] data_adr,
   input  logic [XLEN-1:0] write_data,
   output logic [XLEN-1:0] signature,
   output logic            done,
   output logic            pass,
   output logic            fail,
   output logic            timeout,
   output logic [CW-1:0]   cycle_count,
   output logic [15:0]     store_count,
   output sig_state_e      state
);

   sig_state_e      state_next;
   logic            in_run;
   logic            pass_hit;
   logic            fail_hit;
   logic            last_cycle;
   logic [XLEN-1:0] mix;

   assign in_run = (state == ST_RUN);

   // Any store that is neither the passing store nor the scratch address ends
   // the run as a failure, including a wrong value written to PASS_ADR.
   assign pass_hit   = mem_write && (data_adr == PASS_ADR) && (write_data == PASS_DATA);
   assign fail_hit   = mem_write && !pass_hit && (data_adr != SCRATCH_ADR);
   assign last_cycle = (cycle_count == CW'(TIMEOUT_CYCLES - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // A terminal store on the timeout edge wins over the timeout.
   always_comb begin
      state_next = state;
      if (in_run) begin
         if (pass_hit) begin
            state_next = ST_PASS;
         end else if (fail_hit) begin
            state_next = ST_FAIL;
         end else if (last_cycle) begin
            state_next = ST_TIMEOUT;
         end
      end
   end

   assign done    = !in_run;
   assign pass    = (state == ST_PASS);
   assign fail    = (state == ST_FAIL);
   assign timeout = (state == ST_TIMEOUT);

   // ---------------- counters ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_count <= '0;
         store_count <= '0;
      end else if (in_run) begin
         cycle_count <= cycle_count + 1'b1;
         if (mem_write && (store_count != 16'hFFFF)) begin
            store_count <= store_count + 16'd1;
         end
      end
   end

   // ---------------- signature ----------------
   // The terminating cycle still folds in, since in_run is still true on that edge.
   assign mix = (sample_en ? (instr ^ pc) : '0) ^ (mem_write ? write_data : '0);

   sig_lfsr_reg #(
      .XLEN (XLEN),
      .TAPS (TAPS)
   ) u_sig (
      .clk    (clk),
      .reset  (reset),
      .step   (sample_en || mem_write),
      .freeze (!in_run),
      .mix    (mix),
      .sig    (signature)
   );

endmodule

// File: tb/tb_commit_sig_monitor.sv
// tb_commit_sig_monitor: self-checking bench for commit_sig_monitor
// (XLEN=32, default addresses, TIMEOUT_CYCLES=8).
module tb_commit_sig_monitor;
   import sig_mon_pkg::*;

   localparam int          TO      = 8;
   localparam int          CW      = 4;
   localparam logic [31:0] TB_TAPS = 32'hE000_0200;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sample_en = 1'b0;
   logic [31:0]   instr = '0;
   logic [31:0]   pc = '0;
   logic          mem_write = 1'b0;
   logic [31:0]   data_adr = '0;
   logic [31:0]   write_data = '0;
   logic [31:0]   signature;
   logic          done, pass, fail, timeout;
   logic [CW-1:0] cycle_count;
   logic [15:0]   store_count;
   sig_state_e    state;

   always #5 clk = ~clk;

   commit_sig_monitor #(
      .XLEN           (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_en   (sample_en),
      .instr       (instr),
      .pc          (pc),
      .mem_write   (mem_write),
      .data_adr    (data_adr),
      .write_data  (write_data),
      .signature   (signature),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .cycle_count (cycle_count),
      .store_count (store_count),
      .state       (state)
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0]   sig;
      logic [1:0]    st;
      logic [CW-1:0] cyc;
      logic [15:0]   stc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   logic [31:0]   m_sig;
   sig_state_e    m_st;
   logic [CW-1:0] m_cyc;
   logic [15:0]   m_stc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Bit-serial reference for one signature step.
   function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] mix);
      logic [31:0] t;
      logic        fb;
      t  = s ^ mix;
      fb = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (TB_TAPS[i]) fb = fb ^ t[i];
      end
      return {t[30:0], fb};
   endfunction

   task automatic push_exp();
      exp_t e;
      e.sig = m_sig;
      e.st  = m_st;
      e.cyc = m_cyc;
      e.stc = m_stc;
      exp_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("queue_empty", 64'(exp_q.size()), 64'd1);
         return;
      end
      e = exp_q.pop_front();
      check("signature",   64'(signature),   64'(e.sig));
      check("state",       64'(state),       64'(e.st));
      check("done",        64'(done),        64'(e.st != ST_RUN));
      check("pass",        64'(pass),        64'(e.st == ST_PASS));
      check("fail",        64'(fail),        64'(e.st == ST_FAIL));
      check("timeout",     64'(timeout),     64'(e.st == ST_TIMEOUT));
      check("cycle_count", 64'(cycle_count), 64'(e.cyc));
      check("store_count", 64'(store_count), 64'(e.stc));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic se, input logic [31:0] ins, input logic [31:0] p,
                        input logic mw, input logic [31:0] adr, input logic [31:0] wd);
      logic [31:0]   mix;
      logic [CW-1:0] old_cyc;
      reset      = 1'b1;
      sample_en  = se;
      instr      = ins;
      pc         = p;
      mem_write  = mw;
      data_adr   = adr;
      write_data = wd;
      if (m_st == ST_RUN) begin
         mix = (se ? (ins ^ p) : 32'h0) ^ (mw ? wd : 32'h0);
         if (se || mw) m_sig = model_step(m_sig, mix);
         old_cyc = m_cyc;
         m_cyc   = m_cyc + 1'b1;
         if (mw && m_stc != 16'hFFFF) m_stc = m_stc + 16'd1;
         if (mw && adr == 32'd100)     m_st = (wd == 32'd25) ? ST_PASS : ST_FAIL;
         else if (mw && adr != 32'd96) m_st = ST_FAIL;
         else if (old_cyc == CW'(TO - 1)) m_st = ST_TIMEOUT;
      end
      push_exp();
      @(posedge clk);
      #1;
      compare_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   // Reset with junk on the inputs, which must be ignored.
   task automatic do_reset();
      reset      = 1'b0;
      sample_en  = 1'b1;
      instr      = $urandom;
      pc         = $urandom;
      mem_write  = 1'b1;
      data_adr   = 32'h40;
      write_data = $urandom;
      m_sig = '0;
      m_st  = ST_RUN;
      m_cyc = '0;
      m_stc = '0;
      push_exp();
      @(posedge clk);
      #1;
      compare_out();
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] prog_instr[5];
   logic [31:0] prog_pc[5];
   logic        prog_st[5];
   logic [31:0] prog_wd[5];
   logic [31:0] run1_sig;

   task automatic run_program();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, prog_instr[i], prog_pc[i], prog_st[i], 32'd96, prog_wd[i]);
      end
      drive(1'b1, 32'h0000_0023, 32'h0000_0018, 1'b1, 32'd100, 32'd25);
   endtask

   initial begin
      m_sig = '0;
      m_st  = ST_RUN;
      m_cyc = '0;
      m_stc = '0;

      // Reset state and first sample.
      do_reset();
      drive(1'b1, 32'h0000_0013, 32'h0, 1'b0, 32'h0, 32'h0);
      check("first_sig", 64'(signature), 64'h26);
      check("first_cyc", 64'(cycle_count), 64'd1);

      // Scratch store then passing store; signature freezes afterwards.
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'd96, 32'd7);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'd100, 32'd25);
      check("pass_store_count", 64'(store_count), 64'd2);
      drive(1'b1, 32'h1234_5678, 32'h8, 1'b1, 32'h40, 32'h5);
      idle(2);

      // Wrong data at PASS_ADR, and a store to an unexpected address.
      do_reset();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'd100, 32'd24);
      check("fail_wrong_data", 64'(fail), 64'd1);
      do_reset();
      drive(1'b1, 32'h0000_0093, 32'h4, 1'b1, 32'h40, $urandom);
      check("fail_bad_adr", 64'(fail), 64'd1);

      // Timeout after the 8th clock with no stores.
      do_reset();
      idle(TO);
      check("timeout_flag", 64'(timeout), 64'd1);
      check("timeout_cyc", 64'(cycle_count), 64'(TO));
      idle(2);

      // Passing store on the timeout edge wins.
      do_reset();
      idle(TO - 1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'd100, 32'd25);
      check("edge_pass", 64'(pass), 64'd1);
      check("edge_no_timeout", 64'(timeout), 64'd0);

      // Failing store on the timeout edge wins as well.
      do_reset();
      idle(TO - 1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'd200, 32'd1);
      check("edge_fail", 64'(fail), 64'd1);

      // Reset mid-run, then a random program run twice must reproduce its signature.
      for (int i = 0; i < 5; i++) begin
         prog_instr[i] = $urandom;
         prog_pc[i]    = 32'(4 * i);
         prog_st[i]    = 1'($urandom_range(0, 1));
         prog_wd[i]    = $urandom;
      end
      do_reset();
      drive(1'b1, prog_instr[0], prog_pc[0], 1'b0, 32'h0, 32'h0);
      drive(1'b1, prog_instr[1], prog_pc[1], 1'b1, 32'd96, prog_wd[1]);
      do_reset();
      check("midrun_reset_sig", 64'(signature), 64'h0);
      run_program();
      run1_sig = m_sig;
      idle(1);
      do_reset();
      check("post_pass_reset", 64'({done, pass, fail, timeout}), 64'h0);
      run_program();
      check("rerun_pass", 64'(pass), 64'd1);
      check("rerun_sig", 64'(signature), 64'(run1_sig));

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
